// File: rtl/ocp_mailbox.sv
// OCP-slave mailbox: DATA writes feed a TX byte FIFO, DATA reads drain an RX byte FIFO, with STATUS/CTRL registers and a level interrupt.
// Latency: SCmdAccept comes WAIT_STATES cycles after a command appears (same cycle when 0); SResp/SData are registered one cycle after accept.
// Backpressure: the master holds a command until it is accepted; the streams use valid/ready, and OCP writes to a full TX FIFO are dropped and flagged.
module ocp_mailbox #(
    parameter int DEPTH_LOG2  = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_MAddr,
    input  logic [2:0]  i_MCmd,
    input  logic [31:0] i_MData,
    input  logic [3:0]  i_MByteEn,
    output logic        o_SCmdAccept,
    output logic [31:0] o_SData,
    output logic [1:0]  o_SResp,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic        o_intr
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_WRITE = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);

    logic [7:0]            tx_mem [DEPTH];
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0]         tx_cnt, rx_cnt;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  tx_ovf, rx_unf;
    logic [2:0]            ctrl;
    logic [3:0]            wcnt;

    logic        pending, accept, is_wr, is_rd, bad;
    logic [1:0]  reg_sel;
    logic        tx_push_req, tx_push, tx_pop, rx_pop_req, rx_pop, rx_push;
    logic        ovf_set, unf_set, sts_wr, ctrl_wr;
    logic [31:0] status_val, rd_val;

    // Address/data bits outside the decoded fields are intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{i_MAddr[31:4], i_MAddr[1:0], i_MData[31:8], i_MByteEn[3:1]};

    assign tx_full  = (tx_cnt == CNT_FULL);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CNT_FULL);
    assign rx_empty = (rx_cnt == '0);

    assign o_tx_valid = !tx_empty;
    assign o_tx_data  = tx_mem[tx_rp];
    assign o_rx_ready = !rx_full;

    // Accept is combinational so zero wait states means same-cycle accept.
    assign pending      = (i_MCmd != CMD_IDLE);
    assign accept       = pending && (wcnt == 4'd0) && !rst;
    assign o_SCmdAccept = accept;

    assign reg_sel = i_MAddr[3:2];
    assign is_wr   = (i_MCmd == CMD_WRITE);
    assign is_rd   = (i_MCmd == CMD_READ);
    assign bad     = !(is_wr || is_rd) || (reg_sel == 2'd3);

    // Full/empty seen by the OCP side are the pre-edge values, so a same-cycle
    // stream pop/push never rescues an overflowing write or underflowing read.
    assign tx_push_req = accept && is_wr && (reg_sel == REG_DATA) && i_MByteEn[0];
    assign tx_push     = tx_push_req && !tx_full;
    assign ovf_set     = tx_push_req && tx_full;
    assign tx_pop      = o_tx_valid && i_tx_ready;

    assign rx_pop_req = accept && is_rd && (reg_sel == REG_DATA);
    assign rx_pop     = rx_pop_req && !rx_empty;
    assign unf_set    = rx_pop_req && rx_empty;
    assign rx_push    = i_rx_valid && o_rx_ready;

    assign sts_wr  = accept && is_wr && (reg_sel == REG_STATUS) && i_MByteEn[0];
    assign ctrl_wr = accept && is_wr && (reg_sel == REG_CTRL) && i_MByteEn[0];

    assign status_val = {8'd0, 8'(rx_cnt), 8'(tx_cnt), 2'b00, rx_unf, tx_ovf,
                         rx_empty, rx_full, tx_empty, tx_full};

    // Read-data mux for the accepted command; errors return zero.
    always_comb begin
        rd_val = 32'd0;
        if (!bad && is_rd) begin
            case (reg_sel)
                REG_DATA:   rd_val = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]};
                REG_STATUS: rd_val = status_val;
                REG_CTRL:   rd_val = {29'd0, ctrl};
                default:    rd_val = 32'd0;
            endcase
        end
    end

    // Wait-state counter: counts down while a command waits, reloads on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= 4'(WAIT_STATES);
        end else if (accept) begin
            wcnt <= 4'(WAIT_STATES);
        end else if (pending && wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
        end
    end

    // Registered response: valid exactly the cycle after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_SResp <= RESP_NULL;
            o_SData <= 32'd0;
        end else if (accept) begin
            o_SResp <= bad ? RESP_ERR : RESP_DVA;
            o_SData <= rd_val;
        end else begin
            o_SResp <= RESP_NULL;
            o_SData <= 32'd0;
        end
    end

    // Pointers, counts, sticky flags, CTRL and the interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
            ctrl   <= 3'd0;
            o_intr <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            tx_ovf <= ovf_set || (tx_ovf && !(sts_wr && i_MData[4]));
            rx_unf <= unf_set || (rx_unf && !(sts_wr && i_MData[5]));
            if (ctrl_wr) ctrl <= i_MData[2:0];
            o_intr <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty) ||
                      (ctrl[2] && (tx_ovf || rx_unf));
        end
    end

    // FIFO storage needs no reset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= i_MData[7:0];
        if (rx_push) rx_mem[rx_wp] <= i_rx_data;
    end
endmodule
